// File: rtl/ternary_weight_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// bitnet_pkg
// Shared definitions for the BitNet ternary weight path: 2-bit trit codes
// consumed by the FMA array's weight-control input, base-3 packing constants,
// the unpacker FSM state type and the digit-to-code mapping.
// ---------------------------------------------------------------------------
package bitnet_pkg;

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b11;

    localparam int         TRITS_PER_BYTE = 5;
    localparam logic [7:0] MAX_PACKED     = 8'd242;   // 3^5 - 1

    typedef enum logic {
        IDLE = 1'b0,   // no byte held
        EMIT = 1'b1    // residue of a byte held, codes pending
    } state_t;

    // Base-3 digit (0..2) to trit code. Digit 2 stands for -1.
    function automatic logic [1:0] trit_map(input logic [1:0] digit);
        case (digit)
            2'd0:    trit_map = TRIT_ZERO;
            2'd1:    trit_map = TRIT_POS;
            default: trit_map = TRIT_NEG;
        endcase
    endfunction

endpackage

// File: rtl/ternary_weight_unpacker_if.sv
// ---------------------------------------------------------------------------
// ternary_weight_unpacker_if
// Bundles the packed-byte input stream and the trit-code output stream.
//   in_valid/in_ready/in_data   : packed byte stream (5 trits per byte)
//   out_valid/out_ready         : trit code stream handshake
//   out_code/out_last           : 2-bit trit code, last-weight-of-row tag
// Modports:
//   slave  - the unpacker (consumes bytes, produces codes)
//   master - the environment (weight memory side + FMA consumer)
// ---------------------------------------------------------------------------
interface ternary_weight_unpacker_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic       out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_code, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_code, out_last
    );

endinterface

// File: rtl/ternary_weight_unpacker_digit_split.sv
// ---------------------------------------------------------------------------
// ternary_digit_split
// Combinational split of an 8-bit value into v/3 and v mod 3.
//   v    : value 0..255
//   quot : v / 3 (7 bits)
//   rem  : v mod 3 (2 bits, 0..2)
// ---------------------------------------------------------------------------
module ternary_digit_split (
    input  logic [7:0] v,
    output logic [6:0] quot,
    output logic [1:0] rem
);

    logic [7:0] quot_x3;

    // Reciprocal multiply: 171/512 overshoots 1/3 by 1/1536, so for v <= 255
    // the accumulated error stays below 1/6 and the floor is exact.
    assign quot    = 7'((16'(v) * 16'd171) >> 9);
    assign quot_x3 = {1'b0, quot} * 8'd3;
    assign rem     = 2'(v - quot_x3);

endmodule

// File: rtl/ternary_weight_unpacker.sv
// ---------------------------------------------------------------------------
// ternary_weight_unpacker
// Expands base-3 packed weight bytes (5 trits per byte) into one 2-bit
// ternary code per cycle, tags the last weight of each row and drops the pad
// trits that follow it in the row's final byte.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of ternary_weight_unpacker_if (byte in, code out)
//   err        : sticky, set when a byte above 242 was accepted
// Parameter:
//   ROW_LEN    : weights per row (1..65535)
// ---------------------------------------------------------------------------
module ternary_weight_unpacker
    import bitnet_pkg::*;
#(
    parameter int ROW_LEN = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    ternary_weight_unpacker_if.slave   bus,
    output logic                       err
);

    localparam logic [15:0] LAST_POS  = 16'(ROW_LEN - 1);
    localparam logic [2:0]  LAST_TRIT = 3'(TRITS_PER_BYTE - 1);

    state_t      state_q, state_d;
    logic [7:0]  v_q, v_d;
    logic [2:0]  trit_idx_q, trit_idx_d;
    logic [15:0] row_pos_q, row_pos_d;
    logic        err_q, err_d;

    logic [6:0]  quot;
    logic [1:0]  rem;
    logic        out_fire;
    logic        byte_end;
    logic        in_fire;
    logic        bad_byte;

    ternary_digit_split u_split (
        .v    (v_q),
        .quot (quot),
        .rem  (rem)
    );

    // State register. The residue is data and is only meaningful in EMIT,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            trit_idx_q <= '0;
            row_pos_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            trit_idx_q <= trit_idx_d;
            row_pos_q  <= row_pos_d;
            err_q      <= err_d;
        end
        v_q <= v_d;
    end

    // Outputs and handshakes. in_ready looks at out_ready so a byte can be
    // replaced in the same cycle its final code leaves.
    always_comb begin
        bus.out_valid = (state_q == EMIT);
        bus.out_code  = TRIT_ZERO;
        if (state_q == EMIT) begin
            bus.out_code = trit_map(rem);
        end
        bus.out_last  = (state_q == EMIT) && (row_pos_q == LAST_POS);
        out_fire      = bus.out_valid && bus.out_ready;
        // The row end cuts a byte short; remaining pad trits are never shown.
        byte_end      = out_fire && ((trit_idx_q == LAST_TRIT) || bus.out_last);
        bus.in_ready  = !reset && ((state_q == IDLE) || byte_end);
        in_fire       = bus.in_valid && bus.in_ready;
    end

    // Next state.
    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        trit_idx_d = trit_idx_q;
        row_pos_d  = row_pos_q;
        err_d      = err_q;
        bad_byte   = (bus.in_data > MAX_PACKED);

        if (out_fire) begin
            v_d        = {1'b0, quot};
            trit_idx_d = trit_idx_q + 3'd1;
            row_pos_d  = bus.out_last ? 16'd0 : row_pos_q + 16'd1;
            if (byte_end) begin
                state_d = IDLE;
            end
        end

        // A load overrides the shift of the byte that just ended.
        if (in_fire) begin
            // Out-of-range bytes decode as all-zero weights.
            v_d        = bad_byte ? 8'd0 : bus.in_data;
            trit_idx_d = '0;
            state_d    = EMIT;
            if (bad_byte) begin
                err_d = 1'b1;
            end
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_ternary_weight_unpacker.sv
// ---------------------------------------------------------------------------
// tb_ternary_weight_unpacker
// Scoreboard bench for two unpacker instances (ROW_LEN 64 and 7). Drivers push
// the codes each accepted byte should yield, derived by repeated base-3
// division; monitors pop and compare on every output handshake.
// ---------------------------------------------------------------------------
module tb_ternary_weight_unpacker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ternary_weight_unpacker_if b64 ();
    ternary_weight_unpacker_if b7 ();
    logic err64, err7;

    ternary_weight_unpacker #(.ROW_LEN(64)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (b64.slave),
        .err   (err64)
    );

    ternary_weight_unpacker #(.ROW_LEN(7)) dut7 (
        .clk   (clk),
        .reset (reset),
        .bus   (b7.slave),
        .err   (err7)
    );

    typedef struct packed {
        logic [1:0] code;
        logic       last;
    } exp_t;

    exp_t q64[$];
    exp_t q7[$];
    int   fire_cyc64[$];
    int   pos64, pos7;
    logic err_exp64, err_exp7;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] ref_code(input int digit);
        if (digit == 0)      return 2'b00;
        else if (digit == 1) return 2'b01;
        else                 return 2'b11;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference: peel base-3 digits off the byte value, stopping at the row end.
    task automatic push_byte(input int which, input int b);
        int   val;
        int   rl;
        int   pos;
        exp_t e;
        val = (b > 242) ? 0 : b;
        rl  = (which != 0) ? 7 : 64;
        pos = (which != 0) ? pos7 : pos64;
        for (int i = 0; i < 5; i++) begin
            e.code = ref_code(val % 3);
            e.last = (pos == rl - 1);
            val    = val / 3;
            if (which != 0) q7.push_back(e);
            else            q64.push_back(e);
            if (e.last) begin
                pos = 0;
                break;
            end
            pos++;
        end
        if (which != 0) pos7 = pos;
        else            pos64 = pos;
    endtask

    // Monitors: sample one time unit before each rising edge.
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (!reset) begin
            if (b64.out_valid && b64.out_ready) begin
                if (q64.size() == 0) fail_now("unexpected_code64");
                else begin
                    e = q64.pop_front();
                    check("code64", 32'(b64.out_code), 32'(e.code));
                    check("last64", 32'(b64.out_last), 32'(e.last));
                    fire_cyc64.push_back(cyc);
                end
            end
            if (b7.out_valid && b7.out_ready) begin
                if (q7.size() == 0) fail_now("unexpected_code7");
                else begin
                    e = q7.pop_front();
                    check("code7", 32'(b7.out_code), 32'(e.code));
                    check("last7", 32'(b7.out_last), 32'(e.last));
                end
            end
            check("err64", 32'(err64), 32'(err_exp64));
            check("err7", 32'(err7), 32'(err_exp7));
        end
    end

    task automatic send(input int which, input int b);
        logic rdy;
        @(negedge clk);
        if (which != 0) begin b7.in_valid = 1'b1;  b7.in_data = 8'(b);  end
        else            begin b64.in_valid = 1'b1; b64.in_data = 8'(b); end
        for (int t = 0; t < 300; t++) begin
            #4;
            rdy = (which != 0) ? b7.in_ready : b64.in_ready;
            if (rdy) begin
                push_byte(which, b);
                @(posedge clk);
                if (b > 242) begin
                    if (which != 0) err_exp7 = 1'b1;
                    else            err_exp64 = 1'b1;
                end
                return;
            end
            @(negedge clk);
        end
        fail_now("send_timeout");
    endtask

    task automatic drop(input int which);
        @(negedge clk);
        if (which != 0) b7.in_valid = 1'b0;
        else            b64.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q64.size() == 0 && q7.size() == 0) return;
            @(negedge clk);
        end
        fail_now("drain_timeout");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        b64.in_valid = 1'b0; b7.in_valid = 1'b0;
        b64.out_ready = 1'b1; b7.out_ready = 1'b1;
        err_exp64 = 1'b0; err_exp7 = 1'b0;
        q64.delete(); q7.delete();
        pos64 = 0; pos7 = 0;
        #4;
        check("in_ready_in_reset", 32'(b64.in_ready), 32'd0);
        @(negedge clk);
        #4;
        check("rst_out_valid", 32'(b64.out_valid), 32'd0);
        check("rst_out_code", 32'(b64.out_code), 32'd0);
        check("rst_out_last", 32'(b64.out_last), 32'd0);
        check("rst_err", 32'(err64), 32'd0);
        check("rst_out_valid7", 32'(b7.out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        b64.in_valid = 1'b0; b64.in_data = '0; b64.out_ready = 1'b1;
        b7.in_valid  = 1'b0; b7.in_data  = '0; b7.out_ready  = 1'b1;
        err_exp64 = 1'b0; err_exp7 = 1'b0;
        pos64 = 0; pos7 = 0;
        do_reset();

        // Decode, back to back: 15 codes in 15 consecutive cycles.
        fire_cyc64.delete();
        send(0, 0);
        send(0, 7);
        send(0, 242);
        drop(0);
        drain(100);
        check("nobubble_count", 32'(fire_cyc64.size()), 32'd15);
        if (fire_cyc64.size() == 15)
            check("nobubble_span", 32'(fire_cyc64[14] - fire_cyc64[0]), 32'd14);

        // Row padding on the 7-weight row; the 2nd row proves position restart.
        send(1, 121);
        send(1, 8);
        send(1, 7);
        send(1, 242);
        drop(1);
        drain(100);

        // Backpressure on the 3rd trit of byte 7.
        @(negedge clk);
        b64.out_ready = 1'b0;
        send(0, 7);
        @(negedge clk);
        b64.in_valid  = 1'b0;
        b64.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        b64.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #4;
            check("stall_valid", 32'(b64.out_valid), 32'd1);
            check("stall_code", 32'(b64.out_code), 32'd0);
            check("stall_in_ready", 32'(b64.in_ready), 32'd0);
            @(negedge clk);
        end
        b64.out_ready = 1'b1;
        drain(100);

        // Out-of-range byte, then good bytes with err staying set.
        send(0, 243);
        @(negedge clk);
        #4;
        check("err_set", 32'(err64), 32'd1);
        send(0, 121);
        send(0, 8);
        drop(0);
        drain(100);
        do_reset();

        // Reset during the 2nd trit drops the residue.
        send(0, 7);
        drop(0);
        do_reset();
        send(0, 7);
        // Finish that row: 5 + 12*5 covers 64 with the last byte cut at 4.
        for (int i = 0; i < 12; i++) send(0, int'($urandom_range(0, 242)));
        drop(0);
        drain(200);

        // Three random rows back to back; the third under random backpressure.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 13; i++) send(0, int'($urandom_range(0, 242)));
        fork
            begin
                for (int i = 0; i < 13; i++) send(0, int'($urandom_range(0, 242)));
                drop(0);
            end
            begin
                repeat (100) begin
                    @(negedge clk);
                    b64.out_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                b64.out_ready = 1'b1;
            end
        join
        drain(400);
        check("final_pos64", 32'(pos64), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
